// File: rtl/solo_squash_wb_regs.sv
// Wishbone classic register block for the solo squash game: control,
// status/frame counter, scratch and ID registers at a 16-byte window.
module solo_squash_wb_regs #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int unsigned NEWGAME_CYCLES = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        vsync_i,
  output logic        soft_reset_n_o,
  output logic        pause_n_o,
  output logic        new_game_n_o,
  output logic        up_key_n_o,
  output logic        down_key_n_o,
  output logic        frame_irq_o
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned FRAME_W = 16;
  localparam logic [DATA_W-1:0] ID_VALUE = 32'h5351_5348;
  localparam logic [CNT_W-1:0]  NG_LOAD  = CNT_W'(NEWGAME_CYCLES);

  localparam logic [1:0] OFF_CTRL    = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_SCRATCH = 2'd2;
  localparam logic [1:0] OFF_ID      = 2'd3;

  // Pulse counter is 8 bits wide, so the load value must fit 1..255.
  if (NEWGAME_CYCLES < 1 || NEWGAME_CYCLES > 255) begin : g_bad_param
    $error("NEWGAME_CYCLES out of range 1..255");
  end

  // Register state
  logic              soft_reset;
  logic              pause;
  logic              up_key;
  logic              down_key;
  logic              irq_en;
  logic [CNT_W-1:0]  ng_count;
  logic [FRAME_W-1:0] frame_count;
  logic              frame_flag;
  logic [DATA_W-1:0] scratch;
  logic              vsync_q;

  // Bus decode
  logic              selected;
  logic              accept;
  logic              wr_acc;
  logic              rd_acc;
  logic [1:0]        offset;
  logic              wr_ctrl;
  logic              wr_status;
  logic              wr_scratch;
  logic              ng_start;
  logic              flag_clear;
  logic              vsync_rise;
  logic [DATA_W-1:0] rdata;
  logic              unused;

  assign selected   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign accept     = selected & ~wbs_ack_o;
  assign wr_acc     = accept & wbs_we_i;
  assign rd_acc     = accept & ~wbs_we_i;
  assign offset     = wbs_adr_i[3:2];
  assign wr_ctrl    = wr_acc & (offset == OFF_CTRL);
  assign wr_status  = wr_acc & (offset == OFF_STATUS);
  assign wr_scratch = wr_acc & (offset == OFF_SCRATCH);
  assign ng_start   = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[2];
  assign flag_clear = wr_status & wbs_sel_i[2] & wbs_dat_i[16];
  assign vsync_rise = vsync_i & ~vsync_q;
  assign unused     = &{1'b0, wbs_adr_i[1:0]};

  // Read mux over current register values (pre-write)
  always_comb begin
    rdata = '0;
    case (offset)
      OFF_CTRL:    rdata = {23'd0, irq_en, 3'd0, down_key, up_key,
                            (ng_count != '0), pause, soft_reset};
      OFF_STATUS:  rdata = {15'd0, frame_flag, frame_count};
      OFF_SCRATCH: rdata = scratch;
      OFF_ID:      rdata = ID_VALUE;
      default:     rdata = '0;
    endcase
  end

  // Single-cycle ack with read data registered alongside it
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= accept;
      wbs_dat_o <= rd_acc ? rdata : '0;
    end
  end

  // CTRL level bits
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      soft_reset <= 1'b0;
      pause      <= 1'b0;
      up_key     <= 1'b0;
      down_key   <= 1'b0;
      irq_en     <= 1'b0;
    end else if (wr_ctrl) begin
      if (wbs_sel_i[0]) begin
        soft_reset <= wbs_dat_i[0];
        pause      <= wbs_dat_i[1];
        up_key     <= wbs_dat_i[3];
        down_key   <= wbs_dat_i[4];
      end
      if (wbs_sel_i[1]) begin
        irq_en <= wbs_dat_i[8];
      end
    end
  end

  // New-game pulse counter: reload on write of 1, otherwise count down to 0
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ng_count <= '0;
    end else if (ng_start) begin
      ng_count <= NG_LOAD;
    end else if (ng_count != '0) begin
      ng_count <= ng_count - CNT_W'(1);
    end
  end

  // Vsync edge detect, frame counter and sticky frame flag (set beats clear)
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      vsync_q     <= 1'b0;
      frame_count <= '0;
      frame_flag  <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
      if (vsync_rise) begin
        frame_count <= frame_count + FRAME_W'(1);
      end
      if (vsync_rise) begin
        frame_flag <= 1'b1;
      end else if (flag_clear) begin
        frame_flag <= 1'b0;
      end
    end
  end

  // Byte-enabled scratch register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      scratch <= '0;
    end else if (wr_scratch) begin
      for (int b = 0; b < 4; b++) begin
        if (wbs_sel_i[b]) begin
          scratch[8*b +: 8] <= wbs_dat_i[8*b +: 8];
        end
      end
    end
  end

  // Game controls are inversions of flop outputs only
  assign soft_reset_n_o = ~soft_reset;
  assign pause_n_o      = ~pause;
  assign up_key_n_o     = ~up_key;
  assign down_key_n_o   = ~down_key;
  assign new_game_n_o   = (ng_count == '0);
  assign frame_irq_o    = frame_flag & irq_en;

endmodule

// File: tb/tb_solo_squash_wb_regs.sv
// Self-checking bench for solo_squash_wb_regs with a transaction-level model.
module tb_solo_squash_wb_regs;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          NG   = 16;
  localparam logic [31:0] ID   = 32'h5351_5348;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, dat_w = '0;
  logic        ack;
  logic [31:0] dat_r;
  logic        vsync = 1'b0;
  logic        soft_n, pause_n, ng_n, up_n, down_n, irq;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  solo_squash_wb_regs #(.BASE_ADDR(BASE), .NEWGAME_CYCLES(NG)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
    .vsync_i(vsync), .soft_reset_n_o(soft_n), .pause_n_o(pause_n),
    .new_game_n_o(ng_n), .up_key_n_o(up_n), .down_key_n_o(down_n),
    .frame_irq_o(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Reference model state; the new-game pulse is tracked by the cycle of its last start
  bit          m_soft, m_pause, m_up, m_down, m_irqen, m_flag;
  logic [31:0] m_scratch;
  int          m_fcount;
  int          t_nw;

  function automatic void model_reset();
    m_soft = 0; m_pause = 0; m_up = 0; m_down = 0; m_irqen = 0; m_flag = 0;
    m_scratch = '0; m_fcount = 0; t_nw = -100000;
  endfunction

  function automatic bit ng_active(int t);
    return (t - t_nw) < NG;
  endfunction

  // Read returns the state as it was just before the acknowledging edge
  function automatic logic [31:0] exp_read(int off, int tr);
    logic [31:0] v;
    v = '0;
    case (off)
      0: begin
        v[0] = m_soft; v[1] = m_pause; v[2] = ng_active(tr - 1);
        v[3] = m_up; v[4] = m_down; v[8] = m_irqen;
      end
      1: begin v[15:0] = 16'(m_fcount); v[16] = m_flag; end
      2: v = m_scratch;
      default: v = ID;
    endcase
    return v;
  endfunction

  function automatic void model_write(int off, logic [31:0] d, logic [3:0] s, int tw);
    case (off)
      0: begin
        if (s[0]) begin
          m_soft = d[0]; m_pause = d[1]; m_up = d[3]; m_down = d[4];
          if (d[2]) t_nw = tw;
        end
        if (s[1]) m_irqen = d[8];
      end
      1: if (s[2] && d[16]) m_flag = 0;
      2: for (int b = 0; b < 4; b++) if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
      default: ;
    endcase
  endfunction

  function automatic logic [5:0] exp_outs(int t);
    return {~m_soft, ~m_pause, ~ng_active(t), ~m_up, ~m_down, m_flag & m_irqen};
  endfunction

  // One bus transfer; waits at most 8 edges for the ack
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd,
                         output bit acked, output int tack);
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; dat_w = d; sel = s;
    acked = 0; rd = '0; tack = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin acked = 1; rd = dat_r; tack = cyc_n; break; end
    end
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic vsync_pulse();
    @(negedge clk); vsync = 1;
    @(negedge clk); vsync = 0;
    m_fcount = (m_fcount + 1) % 65536;
    m_flag = 1;
  endtask

  task automatic test_reset();
    checks++;
    if ({ack, dat_r, soft_n, pause_n, ng_n, up_n, down_n, irq} !== {1'b0, 32'h0, 5'b11111, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b dat=%h n=%b%b%b%b%b irq=%b", ack, dat_r,
               soft_n, pause_n, ng_n, up_n, down_n, irq);
    end
    @(negedge clk); rst_n = 1;
    for (int off = 0; off < 4; off++) begin
      logic [31:0] rd; bit acked; int tack;
      wb_xfer(0, BASE + 32'(off * 4), '0, 4'hF, rd, acked, tack);
      checks++;
      if (!acked || rd !== exp_read(off, tack)) begin
        errors++;
        $display("FAIL reset_read off%0d: ack=%0d got %h want %h", off, acked, rd, exp_read(off, tack));
      end
    end
  endtask

  task automatic test_id_window();
    logic [31:0] rd; bit acked; int tack;
    wb_xfer(0, BASE + 32'hC, '0, 4'hF, rd, acked, tack);
    checks++;
    if (!acked || rd !== 32'h5351_5348) begin
      errors++; $display("FAIL id_read: ack=%0d got %h want 53515348", acked, rd);
    end
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0 || dat_r !== 32'h0) begin
      errors++; $display("FAIL ack_one_cycle: ack=%b dat=%h want 0/0", ack, dat_r);
    end
    wb_xfer(1, BASE + 32'hC, 32'h1234_5678, 4'hF, rd, acked, tack);
    wb_xfer(0, BASE + 32'hC, '0, 4'hF, rd, acked, tack);
    checks++;
    if (!acked || rd !== ID) begin
      errors++; $display("FAIL id_ro: ack=%0d got %h want %h", acked, rd, ID);
    end
    wb_xfer(0, BASE + 32'h10, '0, 4'hF, rd, acked, tack);
    checks++;
    if (acked || dat_r !== 32'h0) begin
      errors++; $display("FAIL out_of_window: ack=%0d dat=%h want no ack", acked, dat_r);
    end
  endtask

  task automatic test_scratch();
    logic [31:0] rd; bit acked; int tack;
    wb_xfer(1, BASE + 32'h8, 32'hDEAD_BEEF, 4'b1111, rd, acked, tack);
    model_write(2, 32'hDEAD_BEEF, 4'b1111, tack);
    wb_xfer(1, BASE + 32'h8, 32'h0000_0011, 4'b0001, rd, acked, tack);
    model_write(2, 32'h0000_0011, 4'b0001, tack);
    wb_xfer(0, BASE + 32'h8, '0, 4'hF, rd, acked, tack);
    checks++;
    if (!acked || rd !== 32'hDEAD_BE11 || rd !== m_scratch) begin
      errors++; $display("FAIL scratch_bytes: got %h want deadbe11", rd);
    end
  endtask

  task automatic test_ctrl_newgame();
    logic [31:0] rd; bit acked; int tack; int low;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) repeat (5) @(posedge clk);
      wb_xfer(1, BASE, 32'h0000_0106, 4'b0011, rd, acked, tack);
      model_write(0, 32'h0000_0106, 4'b0011, tack);
      checks++;
      if (pause_n !== 1'b0 || ng_n !== 1'b0) begin
        errors++; $display("FAIL ctrl_write pass%0d: pause_n=%b ng_n=%b want 0/0", pass, pause_n, ng_n);
      end
      if (pass == 0) begin
        low = 0;
        for (int i = 0; i < 40; i++) begin
          if (ng_n === 1'b0) low++;
          @(posedge clk); #1;
        end
        checks++;
        if (low != 16) begin
          errors++; $display("FAIL newgame_len: low %0d cycles want 16", low);
        end
      end else begin
        wb_xfer(0, BASE, '0, 4'hF, rd, acked, tack);
        checks++;
        if (rd !== 32'h106 || rd !== exp_read(0, tack)) begin
          errors++; $display("FAIL ctrl_during_pulse: got %h want 106", rd);
        end
        // restart mid-pulse and measure the remaining low time
        wb_xfer(1, BASE, 32'h0000_0106, 4'b0011, rd, acked, tack);
        model_write(0, 32'h0000_0106, 4'b0011, tack);
        low = 0;
        for (int i = 0; i < 40; i++) begin
          if (ng_n === 1'b0) low++;
          @(posedge clk); #1;
        end
        checks++;
        if (low != 16) begin
          errors++; $display("FAIL newgame_reload: low %0d cycles want 16", low);
        end
        wb_xfer(0, BASE, '0, 4'hF, rd, acked, tack);
        checks++;
        if (rd !== 32'h102 || rd !== exp_read(0, tack)) begin
          errors++; $display("FAIL ctrl_after_pulse: got %h want 102", rd);
        end
      end
    end
  endtask

  task automatic test_frame_wrap();
    logic [31:0] rd; bit acked; int tack;
    wb_xfer(1, BASE, 32'h0000_0100, 4'b0011, rd, acked, tack);
    model_write(0, 32'h0000_0100, 4'b0011, tack);
    wb_xfer(1, BASE + 32'h4, 32'h0001_0000, 4'b0100, rd, acked, tack);
    model_write(1, 32'h0001_0000, 4'b0100, tack);
    // preload the counter just below wrap instead of running 65534 real frames
    @(negedge clk);
    force dut.frame_count = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.frame_count;
    m_fcount = 16'hFFFE;
    vsync_pulse();
    wb_xfer(0, BASE + 32'h4, '0, 4'hF, rd, acked, tack);
    checks++;
    if (rd !== exp_read(1, tack) || rd[15:0] !== 16'hFFFF) begin
      errors++; $display("FAIL frame_ffff: got %h want %h", rd, exp_read(1, tack));
    end
    wb_xfer(1, BASE + 32'h4, 32'h0001_0000, 4'b0100, rd, acked, tack);
    model_write(1, 32'h0001_0000, 4'b0100, tack);
    vsync_pulse();
    wb_xfer(0, BASE + 32'h4, '0, 4'hF, rd, acked, tack);
    checks++;
    if (rd !== 32'h0001_0000 || irq !== 1'b1) begin
      errors++; $display("FAIL frame_wrap: status=%h irq=%b want 00010000/1", rd, irq);
    end
    wb_xfer(1, BASE + 32'h4, 32'h0001_0000, 4'b0100, rd, acked, tack);
    model_write(1, 32'h0001_0000, 4'b0100, tack);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_w1c: irq=%b want 0", irq);
    end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] rd; bit acked; int tack;
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = BASE + 32'h4; dat_w = 32'h0001_0000; sel = 4'b0100;
    vsync = 1;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b1) begin
      errors++; $display("FAIL collision_ack: ack=%b want 1", ack);
    end
    @(negedge clk);
    cyc = 0; stb = 0; we = 0; vsync = 0;
    m_fcount = (m_fcount + 1) % 65536;
    m_flag = 1;
    wb_xfer(0, BASE + 32'h4, '0, 4'hF, rd, acked, tack);
    checks++;
    if (rd !== exp_read(1, tack) || rd[16] !== 1'b1 || irq !== 1'b1) begin
      errors++; $display("FAIL set_wins: status=%h irq=%b want %h/1", rd, irq, exp_read(1, tack));
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'hC; sel = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ack !== ((k % 2) == 0) || dat_r !== (((k % 2) == 0) ? ID : 32'h0)) begin
        errors++; $display("FAIL back_to_back k=%0d: ack=%b dat=%h", k, ack, dat_r);
      end
    end
    @(negedge clk);
    cyc = 0; stb = 0;
  endtask

  task automatic test_random();
    logic [31:0] rd, d, e; bit acked, w; int tack, off; logic [3:0] s;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        vsync_pulse();
      end else begin
        off = $urandom_range(0, 3);
        w = 1'($urandom_range(0, 1));
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        wb_xfer(w, BASE + 32'(off * 4), d, s, rd, acked, tack);
        if (w) begin
          model_write(off, d, s, tack);
        end else begin
          e = exp_read(off, tack);
          checks++;
          if (!acked || rd !== e) begin
            errors++; $display("FAIL rand_read n=%0d off%0d: got %h want %h", n, off, rd, e);
          end
        end
      end
      checks++;
      if ({soft_n, pause_n, ng_n, up_n, down_n, irq} !== exp_outs(cyc_n)) begin
        errors++; $display("FAIL rand_outs n=%0d: got %b want %b", n,
                           {soft_n, pause_n, ng_n, up_n, down_n, irq}, exp_outs(cyc_n));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; bit acked; int tack;
    wb_xfer(1, BASE, 32'h0000_011F, 4'b0011, rd, acked, tack);
    model_write(0, 32'h0000_011F, 4'b0011, tack);
    vsync_pulse();
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'hC; sel = 4'hF;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b1 || ng_n !== 1'b0 || irq !== 1'b1) begin
      errors++; $display("FAIL pre_reset: ack=%b ng_n=%b irq=%b want 1/0/1", ack, ng_n, irq);
    end
    #1 rst_n = 0;
    #1;
    model_reset();
    checks++;
    if ({ack, dat_r, soft_n, pause_n, ng_n, up_n, down_n, irq} !== {1'b0, 32'h0, 5'b11111, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: ack=%b dat=%h n=%b%b%b%b%b irq=%b", ack, dat_r,
               soft_n, pause_n, ng_n, up_n, down_n, irq);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ack !== 1'b0) begin
      errors++; $display("FAIL ack_in_reset: ack=%b want 0", ack);
    end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b1 || dat_r !== ID) begin
      errors++; $display("FAIL retry_after_reset: ack=%b dat=%h want 1/%h", ack, dat_r, ID);
    end
    @(negedge clk);
    cyc = 0; stb = 0;
    wb_xfer(0, BASE, '0, 4'hF, rd, acked, tack);
    checks++;
    if (rd !== 32'h0 || rd !== exp_read(0, tack)) begin
      errors++; $display("FAIL ctrl_after_reset: got %h want 0", rd);
    end
    wb_xfer(0, BASE + 32'h4, '0, 4'hF, rd, acked, tack);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL status_after_reset: got %h want 0", rd);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_id_window();
    test_scratch();
    test_ctrl_newgame();
    test_frame_wrap();
    test_w1c_collision();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/solo_squash_wb_regs.md
SOLO_SQUASH_WB_REGS -- requirements
Module: solo_squash_wb_regs

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3000_0000; base of the 16-byte register window.
REQ-002 Parameter NEWGAME_CYCLES, default 16; low-pulse length of new_game_n_o, range 1..255.
REQ-003 wb_clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-004 wb_rst_n  in  1  asynchronous, active-low reset.
REQ-005 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic bus-cycle, strobe and write-enable.
REQ-006 wbs_sel_i  in  4  byte enables; wbs_adr_i  in  32  byte address; wbs_dat_i  in  32  write data.
REQ-007 wbs_ack_o  out  1  transfer acknowledge; wbs_dat_o  out  32  read data.
REQ-008 vsync_i  in  1  game vsync, synchronous to wb_clk_i, active-high.
REQ-009 soft_reset_n_o, pause_n_o, new_game_n_o, up_key_n_o, down_key_n_o  out  1 each  active-low game controls.
REQ-010 frame_irq_o  out  1  frame interrupt to user_irq[0].

Function
REQ-011 Selected = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]); offset = wbs_adr_i[3:2].
REQ-012 Selected with wbs_ack_o low: block SHALL assert wbs_ack_o on the next edge for exactly one cycle; write/read takes effect on that same edge.
REQ-013 Selected while wbs_ack_o high SHALL not be accepted; hence minimum two cycles per transfer, no back-to-back acks.
REQ-014 Not selected: no ack, no register change; wbs_dat_o SHALL be 0 whenever wbs_ack_o is low.
REQ-015 Offset 0 CTRL (RW): bit0 soft_reset, bit1 pause, bit3 up, bit4 down, bit8 irq_en; bits 0-4 written under wbs_sel_i[0], bit8 under wbs_sel_i[1]; other bits read 0.
REQ-016 CTRL bit2 new_game: writing 1 (sel[0]) loads a pulse counter with NEWGAME_CYCLES; bit reads 1 while counter nonzero; writing 0 has no effect.
REQ-017 new_game_n_o SHALL be low exactly while the pulse counter is nonzero; counter decrements by 1 per cycle; a new write of 1 mid-pulse reloads to NEWGAME_CYCLES.
REQ-018 soft_reset_n_o = ~CTRL[0]; pause_n_o = ~CTRL[1]; up_key_n_o = ~CTRL[3]; down_key_n_o = ~CTRL[4]; all registered, no combinational path from bus.
REQ-019 Offset 1 STATUS: bits[15:0] frame_count (RO), bit16 frame_flag (W1C under sel[2]), other bits 0.
REQ-020 vsync rising edge = vsync_i high with previous-cycle sample low; each edge increments frame_count modulo 2^16 (0xFFFF -> 0x0000).
REQ-021 Each vsync rising edge SHALL set frame_flag regardless of irq_en.
REQ-022 frame_flag set and W1C clear on the same edge: set wins, flag stays 1.
REQ-023 frame_irq_o = frame_flag & CTRL[8], registered-source, no bus-combinational path.
REQ-024 Offset 2 SCRATCH (RW 32-bit): each byte written only when corresponding wbs_sel_i bit set.
REQ-025 Offset 3 ID (RO): reads 32'h5351_5348; writes ignored but acked.
REQ-026 Read data SHALL reflect register values before any same-cycle write (registered with ack).

Reset
REQ-027 wb_rst_n low SHALL immediately, without clock: wbs_ack_o=0, wbs_dat_o=0, CTRL=0, pulse counter=0, frame_count=0, frame_flag=0, SCRATCH=0, vsync sample=0.
REQ-028 Hence during reset: soft_reset_n_o=1, pause_n_o=1, new_game_n_o=1, up/down_key_n_o=1, frame_irq_o=0.
REQ-029 Reset asserted mid-transfer SHALL abort it with no ack; after release the master retry SHALL complete normally.
REQ-030 Reset asserted mid new_game pulse SHALL return new_game_n_o high immediately.

Verification
REQ-031 Read BASE+0xC -> one-cycle ack, wbs_dat_o=32'h5351_5348; read BASE+0x10 -> no ack in 8 cycles.
REQ-032 Write SCRATCH 32'hDEAD_BEEF sel=4'b1111, then 32'h0000_0011 sel=4'b0001 -> readback 32'hDEAD_BE11.
REQ-033 Write CTRL 32'h0000_0106 -> pause_n_o=0, new_game_n_o low exactly 16 cycles after ack edge, irq_en=1; CTRL readback 32'h106 during pulse, 32'h102 after.
REQ-034 Preload 65535 vsync edges, one more -> frame_count=0x0000, frame_flag=1, frame_irq_o=1; W1C 32'h0001_0000 sel=4'b0100 -> frame_irq_o=0.
REQ-035 W1C on same cycle as vsync rising edge -> frame_flag remains 1; stb held high continuously -> acks on alternate cycles only.
REQ-036 Pull wb_rst_n low mid-read and mid-pulse -> ack=0, dat=0, all _n outputs 1 before next clock edge.
